// File: rtl/mainmem_responder_if.sv
// Request/response bundle between the cache arbiter (master) and mainmem_responder (slave).
// The err signal exists only when MAINMEM_ALIGN_CHK_EN is defined.
interface mainmem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 4
);
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data_in;
    logic [15:0]       data_out;
    logic              data_valid;
    logic [CNT_W-1:0]  outstanding;
`ifdef MAINMEM_ALIGN_CHK_EN
    logic              err;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, outstanding, err
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, outstanding, err
    );
`else
    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, outstanding
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, outstanding
    );
`endif
endinterface

// File: rtl/mainmem_responder.sv
// Fully pipelined word-addressed main memory: one request per cycle, reads return after LATENCY cycles.
// Optional feature macro MAINMEM_ALIGN_CHK_EN rejects odd byte addresses and pulses err.
module mainmem_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mainmem_responder_if.slave bus
);
    localparam int WORDS = 1 << (ADDR_W - 1);

    logic [15:0]       mem [WORDS];
    logic [ADDR_W-2:0] word_idx;
    logic              misaligned;
    logic              accept;
    logic              accept_rd;
    logic              accept_wr;

    logic              pipe_valid [LATENCY];
    logic [15:0]       pipe_data  [LATENCY];
    logic              ret_valid;
    logic [CNT_W-1:0]  outstanding;

    assign word_idx = bus.addr[ADDR_W-1:1];

`ifdef MAINMEM_ALIGN_CHK_EN
    logic err_q;

    assign misaligned = bus.addr[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bus.enable & misaligned;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = bus.addr[0];
    assign misaligned      = 1'b0;
`endif

    // Requests seen while in reset are dropped entirely, including writes.
    assign accept    = rst_n & bus.enable & ~misaligned;
    assign accept_rd = accept & ~bus.wr;
    assign accept_wr = accept &  bus.wr;

    // Storage has no reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem[word_idx] <= bus.data_in;
        end
    end

    // Read data is captured at acceptance, so later writes cannot alter an in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept_rd;
            pipe_data[0]  <= accept_rd ? mem[word_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign ret_valid = pipe_valid[LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (accept_rd && !ret_valid) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!accept_rd && ret_valid) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    assign bus.data_valid  = ret_valid;
    assign bus.data_out    = ret_valid ? pipe_data[LATENCY-1] : 16'h0000;
    assign bus.outstanding = outstanding;
endmodule

// File: tb/tb_mainmem_responder.sv
// Directed, table-driven bench for mainmem_responder at LATENCY=4.
// Expected err values are checked only when MAINMEM_ALIGN_CHK_EN is defined.
module tb_mainmem_responder;
    localparam int LATENCY = 4;
    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 4;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_dv;
        logic [15:0] exp_do;
        logic [3:0]  exp_out;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    vec_t vecs[$];

    mainmem_responder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    mainmem_responder #(
        .LATENCY(LATENCY),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] din);
        rst_n       = rst;
        bus.enable  = en;
        bus.wr      = wr;
        bus.addr    = addr;
        bus.data_in = din;
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_dv, input logic [15:0] exp_do,
                               input logic [3:0] exp_out, input logic exp_err);
        compare({tag, "_dv"}, {31'd0, bus.data_valid}, {31'd0, exp_dv});
        compare({tag, "_do"}, {16'd0, bus.data_out}, {16'd0, exp_do});
        compare({tag, "_out"}, {28'd0, bus.outstanding}, {28'd0, exp_out});
`ifdef MAINMEM_ALIGN_CHK_EN
        compare({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
`else
        if (exp_err !== 1'b0) begin
            compare({tag, "_err_absent"}, 32'd1, 32'd0);
        end
`endif
    endtask

    task automatic addVec(input logic en, input logic wr, input logic [15:0] addr, input logic [15:0] din,
                          input logic dv, input logic [15:0] dout, input logic [3:0] out, input logic err);
        vec_t v;
        v.en      = en;
        v.wr      = wr;
        v.addr    = addr;
        v.din     = din;
        v.exp_dv  = dv;
        v.exp_do  = dout;
        v.exp_out = out;
        v.exp_err = err;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic dv, input logic [15:0] dout, input logic [3:0] out, input logic err);
        addVec(1'b0, 1'b0, 16'h0000, 16'h0000, dv, dout, out, err);
    endtask

    initial begin
        logic [15:0] got;
        int          lat;

        checks = 0;
        passes = 0;

        // Each row: expected outputs in this cycle, inputs presented during this cycle.
        addVec(1, 1, 16'h0020, 16'hBEEF, 0, 16'h0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            addVec(1, 1, 16'h0100 + 16'(2 * k), 16'h1000 + 16'(k), 0, 16'h0, 0, 0);
        end
        addVec(1, 0, 16'h0020, 16'h0, 0, 16'h0, 0, 0);
        idle(0, 16'h0, 1, 0);
        idle(0, 16'h0, 1, 0);
        idle(0, 16'h0, 1, 0);
        idle(1, 16'hBEEF, 1, 0);
        idle(0, 16'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            addVec(1, 0, 16'h0100 + 16'(2 * k), 16'h0, 0, 16'h0, 4'(k), 0);
        end
        for (int k = 4; k < 8; k++) begin
            addVec(1, 0, 16'h0100 + 16'(2 * k), 16'h0, 1, 16'h1000 + 16'(k - 4), 4, 0);
        end
        idle(1, 16'h1004, 4, 0);
        idle(1, 16'h1005, 3, 0);
        idle(1, 16'h1006, 2, 0);
        idle(1, 16'h1007, 1, 0);
        addVec(1, 1, 16'h0040, 16'h1234, 0, 16'h0, 0, 0);
        addVec(1, 0, 16'h0040, 16'h0, 0, 16'h0, 0, 0);
        idle(0, 16'h0, 1, 0);
        idle(0, 16'h0, 1, 0);
        idle(0, 16'h0, 1, 0);
        idle(1, 16'h1234, 1, 0);
        addVec(1, 1, 16'h0040, 16'h00AA, 0, 16'h0, 0, 0);
        addVec(1, 0, 16'h0040, 16'h0, 0, 16'h0, 0, 0);
        addVec(1, 1, 16'h0040, 16'h5555, 0, 16'h0, 1, 0);
        addVec(1, 0, 16'h0040, 16'h0, 0, 16'h0, 1, 0);
        idle(0, 16'h0, 2, 0);
        idle(1, 16'h00AA, 2, 0);
        idle(0, 16'h0, 1, 0);
        idle(1, 16'h5555, 1, 0);
        addVec(1, 0, 16'h0021, 16'h0, 0, 16'h0, 0, 0);
`ifdef MAINMEM_ALIGN_CHK_EN
        idle(0, 16'h0, 0, 1);
        idle(0, 16'h0, 0, 0);
        idle(0, 16'h0, 0, 0);
        idle(0, 16'h0, 0, 0);
        idle(0, 16'h0, 0, 0);
`else
        idle(0, 16'h0, 1, 0);
        idle(0, 16'h0, 1, 0);
        idle(0, 16'h0, 1, 0);
        idle(1, 16'hBEEF, 1, 0);
        idle(0, 16'h0, 0, 0);
`endif

        applyStimulus(0, 0, 0, 16'h0, 16'h0);
        nextCycle();
        nextCycle();

        foreach (vecs[i]) begin
            checkOutput($sformatf("row%0d", i), vecs[i].exp_dv, vecs[i].exp_do, vecs[i].exp_out, vecs[i].exp_err);
            applyStimulus(1, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
            nextCycle();
        end

        // Reset mid-burst: three reads in flight, then a reset cycle carrying a write.
        checkOutput("rst_c0", 0, 16'h0, 0, 0);
        applyStimulus(1, 1, 0, 16'h0100, 16'h0);
        nextCycle();
        applyStimulus(1, 1, 0, 16'h0102, 16'h0);
        nextCycle();
        applyStimulus(1, 1, 0, 16'h0104, 16'h0);
        nextCycle();
        checkOutput("rst_c3", 0, 16'h0, 3, 0);
        applyStimulus(0, 1, 1, 16'h0100, 16'hDEAD);
        nextCycle();
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        for (int c = 4; c < 8; c++) begin
            checkOutput($sformatf("rst_c%0d", c), 0, 16'h0, 0, 0);
            nextCycle();
        end

        // The write issued during reset must not have landed.
        applyStimulus(1, 1, 0, 16'h0100, 16'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        lat = 0;
        got = 16'h0;
        for (int i = 1; i <= 8; i++) begin
            if (bus.data_valid === 1'b1) begin
                lat = i;
                got = bus.data_out;
                break;
            end
            nextCycle();
        end
        compare("post_rst_latency", 32'(lat), 32'(LATENCY));
        compare("post_rst_retained", {16'd0, got}, 32'h1000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
